// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

  typedef enum logic [1:0] {IDLE, OP, DONE} bin2bcd_state_t;

  localparam int unsigned BCD_W      = 4;
  localparam int unsigned ADJ_THRESH = 5;
  localparam int unsigned ADJ_ADD    = 3;

  // True when DIGITS decimal digits can hold every BIN_W-bit value.
  function automatic bit bcd_fits(input int unsigned bin_w, input int unsigned digits);
    longint unsigned p10;
    longint unsigned max_bin;
    p10 = 64'd1;
    for (int unsigned i = 0; i < digits; i++) p10 = p10 * 64'd10;
    max_bin = (64'd1 << bin_w) - 64'd1;
    return p10 > max_bin;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_bcd_digit_adj.sv
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more before the shift.
module bcd_digit_adj
  import bin2bcd_pkg::*;
(
  input  logic [BCD_W-1:0] digit,
  output logic [BCD_W-1:0] adj_c
);

  always_comb begin
    adj_c = digit;
    if (digit >= BCD_W'(ADJ_THRESH)) adj_c = digit + BCD_W'(ADJ_ADD);
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative shift-add-3 binary-to-BCD converter, one input bit per clock, start/done handshake.
// Optional leading-zero blank flags are built when BIN2BCD_BLANK_EN is defined.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int unsigned BIN_W  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_start,
  input  logic [BIN_W-1:0]          i_bin,
  output logic                      o_ready,
  output logic                      o_done,
  output logic [BCD_W*DIGITS-1:0]   o_bcd,
  output logic [DIGITS-1:0]         o_blank
);

  localparam int unsigned BCD_TOT = BCD_W * DIGITS;
  localparam int unsigned CNT_W   = $clog2(BIN_W + 1);

  if (!bcd_fits(BIN_W, DIGITS)) begin : g_bad_params
    $error("bin2bcd_seq: 10^DIGITS must exceed 2^BIN_W-1");
  end

  bin2bcd_state_t       state;
  logic [BIN_W-1:0]     bin_q;
  logic [BCD_TOT-1:0]   bcd_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [BCD_TOT-1:0]   bcd_adj_c;
  logic [BCD_TOT-1:0]   bcd_shift_c;
  logic                 last_c;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit (bcd_q[g*BCD_W +: BCD_W]),
      .adj_c (bcd_adj_c[g*BCD_W +: BCD_W])
    );
  end

  // Next BCD value: adjusted digits shifted left, taking in the binary MSB.
  assign bcd_shift_c = {bcd_adj_c[BCD_TOT-2:0], bin_q[BIN_W-1]};
  assign last_c      = (cnt_q == CNT_W'(BIN_W - 1));

`ifdef BIN2BCD_BLANK_EN
  logic [DIGITS-1:0] blank_c;
  logic              zero_run;

  // A digit blanks only if it and every digit above it are zero; digit 0 always shows.
  always_comb begin
    blank_c  = '0;
    zero_run = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      zero_run   = zero_run && (bcd_shift_c[i*BCD_W +: BCD_W] == '0);
      blank_c[i] = zero_run;
    end
  end
`else
  assign o_blank = '0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      o_ready <= 1'b1;
      o_done  <= 1'b0;
      o_bcd   <= '0;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
`ifdef BIN2BCD_BLANK_EN
      o_blank <= '0;
`endif
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            bin_q   <= i_bin;
            bcd_q   <= '0;
            cnt_q   <= '0;
            o_ready <= 1'b0;
            state   <= OP;
          end
        end
        OP: begin
          bin_q <= {bin_q[BIN_W-2:0], 1'b0};
          bcd_q <= bcd_shift_c;
          cnt_q <= cnt_q + CNT_W'(1);
          // Outputs only change here, so the display never sees partial results.
          if (last_c) begin
            state  <= DONE;
            o_done <= 1'b1;
            o_bcd  <= bcd_shift_c;
`ifdef BIN2BCD_BLANK_EN
            o_blank <= blank_c;
`endif
          end
        end
        DONE: begin
          state   <= IDLE;
          o_ready <= 1'b1;
        end
        default: begin
          state   <= IDLE;
          o_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: cycle model for the default build plus a 10-bit/4-digit instance.
module tb_bin2bcd_seq;

  localparam int unsigned BIN_W  = 8;
  localparam int unsigned DIGITS = 3;
  localparam int unsigned W2     = 10;
  localparam int unsigned D2     = 4;
`ifdef BIN2BCD_BLANK_EN
  localparam bit BLANK_ON = 1'b1;
`else
  localparam bit BLANK_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  bin = '0;
  logic        ready, done;
  logic [11:0] bcd;
  logic [2:0]  blank;

  logic        start10 = 1'b0;
  logic [9:0]  bin10 = '0;
  logic        ready10, done10;
  logic [15:0] bcd10;
  logic [3:0]  blank10;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_bin(bin),
    .o_ready(ready), .o_done(done), .o_bcd(bcd), .o_blank(blank)
  );

  bin2bcd_seq #(.BIN_W(W2), .DIGITS(D2)) u_dut10 (
    .i_clk(clk), .i_rst(rst), .i_start(start10), .i_bin(bin10),
    .o_ready(ready10), .o_done(done10), .o_bcd(bcd10), .o_blank(blank10)
  );

  // Decimal digits of v, least significant digit in bits [3:0].
  function automatic logic [15:0] to_bcd(input int unsigned v, input int unsigned nd);
    logic [15:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int unsigned d = 0; d < nd; d++) begin
      r[d*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Digit d>0 is blank when v has fewer than d+1 decimal digits.
  function automatic logic [3:0] to_blank(input int unsigned v, input int unsigned nd);
    logic [3:0] r;
    int unsigned p;
    r = '0;
    p = 1;
    for (int unsigned d = 1; d < nd; d++) begin
      p = p * 10;
      r[d] = BLANK_ON && (v < p);
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle model of the default instance: countdown from acceptance to done.
  int unsigned m_left = 0;
  int unsigned m_pend = 0;
  logic        m_ready = 1'b1;
  logic        m_done = 1'b0;
  logic [11:0] m_bcd = '0;
  logic [2:0]  m_blank = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_left = 0; m_ready = 1'b1; m_done = 1'b0; m_bcd = '0; m_blank = '0;
    end else if (m_left == 0) begin
      m_done = 1'b0;
      if (start) begin
        m_pend  = int'(bin);
        m_left  = BIN_W + 1;
        m_ready = 1'b0;
      end else begin
        m_ready = 1'b1;
      end
    end else begin
      m_left = m_left - 1;
      m_done = 1'b0;
      if (m_left == 1) begin
        m_done  = 1'b1;
        m_bcd   = 12'(to_bcd(m_pend, DIGITS));
        m_blank = 3'(to_blank(m_pend, DIGITS));
      end else if (m_left == 0) begin
        m_ready = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_ready", 32'(ready), 32'(m_ready));
      check("model_done",  32'(done),  32'(m_done));
      check("model_bcd",   32'(bcd),   32'(m_bcd));
      check("model_blank", 32'(blank), 32'(m_blank));
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  // One conversion on the default instance; returns sampled in the done cycle.
  task automatic run_conv(input logic [7:0] v, input logic [11:0] exp_bcd, input logic [2:0] exp_blank_on);
    int n;
    bit hold_ok, busy_ok;
    logic [11:0] prev;
    prev = bcd;
    step(); start = 1'b1; bin = v;
    step(); start = 1'b0; bin = 8'($urandom);
    n = 1; hold_ok = 1'b1; busy_ok = 1'b1;
    while (!done && n < 30) begin
      if (ready) busy_ok = 1'b0;
      if (bcd !== prev) hold_ok = 1'b0;
      step(); n++;
    end
    check("latency", 32'(n), 32'(BIN_W + 1));
    check("busy_ready_low", 32'(busy_ok), 32'd1);
    check("hold_prev", 32'(hold_ok), 32'd1);
    check("result_bcd", 32'(bcd), 32'(exp_bcd));
    check("result_blank", 32'(blank), BLANK_ON ? 32'(exp_blank_on) : 32'd0);
  endtask

  task automatic run10(input logic [9:0] v, input logic [15:0] exp_bcd, input logic [3:0] exp_blank);
    int n;
    step(); start10 = 1'b1; bin10 = v;
    step(); start10 = 1'b0; bin10 = 10'($urandom);
    n = 1;
    while (!done10 && n < 40) begin step(); n++; end
    check("w10_latency", 32'(n), 32'(W2 + 1));
    check("w10_bcd", 32'(bcd10), 32'(exp_bcd));
    check("w10_blank", 32'(blank10), 32'(exp_blank));
  endtask

  initial begin
    int ndone;
    bit no_done;
    logic [11:0] e12;
    logic [2:0]  b3;

    // Reset state
    step();
    chk_en = 1'b1;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_done",  32'(done),  32'd0);
    check("rst_bcd",   32'(bcd),   32'd0);
    check("rst_blank", 32'(blank), 32'd0);
    step(); step();
    rst = 1'b0;

    // Max input, latency and ready return
    run_conv(8'd255, 12'h255, 3'b000);
    step();
    check("ready_after_done", 32'(ready), 32'd1);

    // Zero and blanking
    run_conv(8'd0, 12'h000, 3'b110);

    // Back-to-back, each start on the first ready cycle
    run_conv(8'd100, 12'h100, 3'b000);
    run_conv(8'd7,   12'h007, 3'b110);

    // Second start while busy is ignored
    step(); start = 1'b1; bin = 8'd42;
    ndone = 0;
    for (int c = 1; c <= 20; c++) begin
      step();
      start = (c == 4);
      if (c == 4) bin = 8'd99;
      if (done) begin
        ndone++;
        check("busy_start_cycle", 32'(c), 32'd9);
        check("busy_start_bcd", 32'(bcd), 32'h042);
      end
    end
    start = 1'b0;
    check("busy_start_pulses", 32'(ndone), 32'd1);

    // Reset mid-conversion
    step(); start = 1'b1; bin = 8'd200;
    no_done = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      step();
      start = 1'b0;
      rst = (c == 5);
      if (c == 6) begin
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_bcd", 32'(bcd), 32'd0);
      end
      if (done) no_done = 1'b0;
    end
    check("abort_no_done", 32'(no_done), 32'd1);
    run_conv(8'd200, 12'h200, 3'b000);

    // Exhaustive sweep
    for (int v = 0; v < 256; v++) begin
      e12 = 12'(to_bcd(v, DIGITS));
      b3  = 3'(to_blank(v, DIGITS));
      run_conv(8'(v), e12, b3);
      if (bcd[3:0] > 4'd9 || bcd[7:4] > 4'd9 || bcd[11:8] > 4'd9)
        check("digit_range", 32'(bcd), 32'(e12));
      else
        checks++;
    end

    // Wide configuration
    run10(10'd1023, 16'h1023, 4'b0000);
    run10(10'd5, 16'h0005, BLANK_ON ? 4'b1110 : 4'b0000);
    for (int k = 0; k < 20; k++) begin
      int unsigned v;
      v = $urandom_range(0, 1023);
      run10(10'(v), to_bcd(v, D2), to_blank(v, D2));
    end

    // Random traffic, including starts while busy and occasional resets
    for (int c = 0; c < 3000; c++) begin
      step();
      start = ($urandom_range(0, 2) == 0);
      bin   = 8'($urandom);
      rst   = ($urandom_range(0, 96) == 0);
    end
    step(); start = 1'b0; rst = 1'b0;
    for (int c = 0; c < 12; c++) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
